// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame geometry and
// the data-parity helper used by both directions of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DBIT_DEFAULT       = 8;
  localparam int DATA_MAX           = 8;

  // Even parity of a zero-extended data word (narrower words are padded with 0).
  function automatic logic data_parity(input logic [DATA_MAX-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-host bundle: per-frame configuration in, received word,
// completion strobe and status out.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEFAULT
);

  logic            parity_en;
  logic            parity_odd;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            parity_err;
  logic            frame_err;
  logic            busy;

  modport master (
    input  parity_en,
    input  parity_odd,
    output dout,
    output rx_done_tick,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output parity_en,
    output parity_odd,
    input  dout,
    input  rx_done_tick,
    input  parity_err,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to
// RST_VAL so an idle line does not look like an edge after reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff_r;

  // Shift the asynchronous input through the two-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_r <= {2{RST_VAL}};
    end else begin
      ff_r <= {ff_r[0], d};
    end
  end

  assign q = ff_r[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start detection, mid-bit sampling of data,
// optional parity and stop bit, one-cycle done strobe with error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  input  logic      s_tick,
  uart_rx_if.master rx_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DBIT);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

  logic rx_s;

  rx_state_t       state_r, state_n;
  logic [TW-1:0]   tcnt_r, tcnt_n;
  logic [BW-1:0]   bcnt_r, bcnt_n;
  logic [DBIT-1:0] shreg_r, shreg_n;
  logic            pen_r, pen_n;
  logic            podd_r, podd_n;
  logic            pbit_r, pbit_n;
  logic [DBIT-1:0] dout_r, dout_n;
  logic            done_r, done_n;
  logic            perr_r, perr_n;
  logic            ferr_r, ferr_n;
  logic            busy_r, busy_n;

  logic [DATA_MAX-1:0] data_ext_s;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Zero-extend the assembled word for the shared parity helper.
  always_comb begin
    data_ext_s              = {DATA_MAX{1'b0}};
    data_ext_s[DBIT-1:0]    = shreg_r;
  end

  // Next-state and datapath decisions; all line sampling uses the synchronised rx_s.
  always_comb begin
    state_n = state_r;
    tcnt_n  = tcnt_r;
    bcnt_n  = bcnt_r;
    shreg_n = shreg_r;
    pen_n   = pen_r;
    podd_n  = podd_r;
    pbit_n  = pbit_r;
    dout_n  = dout_r;
    perr_n  = perr_r;
    ferr_n  = ferr_r;
    done_n  = 1'b0;

    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          tcnt_n  = {TW{1'b0}};
          pen_n   = rx_if.parity_en;
          podd_n  = rx_if.parity_odd;
        end else begin
          tcnt_n  = {TW{1'b0}};
        end
      end

      START: begin
        if (s_tick) begin
          if (tcnt_r == T_MID) begin
            // A start bit that is high again at its midpoint is a glitch.
            if (!rx_s) begin
              state_n = DATA;
              tcnt_n  = {TW{1'b0}};
              bcnt_n  = {BW{1'b0}};
            end else begin
              state_n = IDLE;
            end
          end else begin
            tcnt_n = tcnt_r + TW'(1);
          end
        end else begin
          tcnt_n = tcnt_r;
        end
      end

      DATA: begin
        if (s_tick) begin
          if (tcnt_r == T_END) begin
            shreg_n = {rx_s, shreg_r[DBIT-1:1]};
            tcnt_n  = {TW{1'b0}};
            if (bcnt_r == B_LAST) begin
              state_n = pen_r ? PARITY : STOP;
            end else begin
              bcnt_n = bcnt_r + BW'(1);
            end
          end else begin
            tcnt_n = tcnt_r + TW'(1);
          end
        end else begin
          tcnt_n = tcnt_r;
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (tcnt_r == T_END) begin
            pbit_n  = rx_s;
            tcnt_n  = {TW{1'b0}};
            state_n = STOP;
          end else begin
            tcnt_n = tcnt_r + TW'(1);
          end
        end else begin
          tcnt_n = tcnt_r;
        end
      end

      STOP: begin
        if (s_tick) begin
          if (tcnt_r == T_END) begin
            // Leaving at mid stop bit lets the next start edge land in its second half.
            done_n  = 1'b1;
            dout_n  = shreg_r;
            ferr_n  = !rx_s;
            perr_n  = pen_r ? (data_parity(data_ext_s) ^ pbit_r ^ podd_r) : 1'b0;
            tcnt_n  = {TW{1'b0}};
            state_n = IDLE;
          end else begin
            tcnt_n = tcnt_r + TW'(1);
          end
        end else begin
          tcnt_n = tcnt_r;
        end
      end

      default: begin
        state_n = IDLE;
        tcnt_n  = {TW{1'b0}};
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      tcnt_r  <= {TW{1'b0}};
      bcnt_r  <= {BW{1'b0}};
      shreg_r <= {DBIT{1'b0}};
      pen_r   <= 1'b0;
      podd_r  <= 1'b0;
      pbit_r  <= 1'b0;
      dout_r  <= {DBIT{1'b0}};
      done_r  <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      tcnt_r  <= tcnt_n;
      bcnt_r  <= bcnt_n;
      shreg_r <= shreg_n;
      pen_r   <= pen_n;
      podd_r  <= podd_n;
      pbit_r  <= pbit_n;
      dout_r  <= dout_n;
      done_r  <= done_n;
      perr_r  <= perr_n;
      ferr_r  <= ferr_n;
      busy_r  <= busy_n;
    end
  end

  assign rx_if.dout         = dout_r;
  assign rx_if.rx_done_tick = done_r;
  assign rx_if.parity_err   = perr_r;
  assign rx_if.frame_err    = ferr_r;
  assign rx_if.busy         = busy_r;

endmodule
